// File: rtl/bram_stream_reader.sv
// Streams a contiguous run of BRAM words onto a valid/ready interface. It tracks the
// BRAM's enable-gated 2-cycle read pipeline and holds back reads so the output FIFO never overflows.
module bram_stream_reader #(
  parameter int RAM_WIDTH    = 32,
  parameter int L2_RAM_DEPTH = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clka,
  input  logic                    rstb,
  input  logic                    start,
  input  logic [L2_RAM_DEPTH-1:0] base_addr,
  input  logic [L2_RAM_DEPTH:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic                    bram_enb,
  output logic [L2_RAM_DEPTH-1:0] bram_addrb,
  input  logic [RAM_WIDTH-1:0]    bram_doutb,
  output logic [RAM_WIDTH-1:0]    m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [1:0]              dbg_state
);

  localparam int AW = L2_RAM_DEPTH;
  localparam int LW = L2_RAM_DEPTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, issued_q;
  logic [AW-1:0]   addr_q;
  logic            v1_q, v2_q, l1_q, l2_q, enb_q;
  logic            done_q, done_d;
  logic            issue, last_issue, credit_ok, push, pop, accept;
  logic [CW:0]     credit_need;

  logic [RAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                 fifo_last [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q;

  // Stream handshake: a word transfers in any cycle where m_valid and m_ready are both high;
  // m_data and m_last stay stable while m_valid is high and m_ready is low.
  assign m_valid = (count_q != '0);
  assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last  = m_valid & fifo_last[rd_ptr];
  assign pop     = m_valid & m_ready;

  // Occupancy is counted before this cycle's pop so the bound holds whatever m_ready does.
  assign credit_need = {1'b0, count_q} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q}
                     + (CW+1)'(1);
  assign credit_ok   = (credit_need <= (CW+1)'(FIFO_DEPTH));
  assign last_issue  = ((issued_q + LW'(1)) == len_q);
  assign accept      = (state_q == S_IDLE) && start && (length != '0);

  assign bram_enb   = (state_q != S_IDLE) | v1_q | v2_q;
  assign bram_addrb = addr_q;
  assign push       = v2_q & enb_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) state_d = S_ISSUE;
          else              done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last[rd_ptr]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      len_q    <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      l1_q     <= 1'b0;
      l2_q     <= 1'b0;
      enb_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      enb_q   <= bram_enb;
      if (accept) begin
        len_q    <= length;
        addr_q   <= base_addr;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + AW'(1);
        issued_q <= issued_q + LW'(1);
      end
      // Valid tags move only when enb advances the BRAM registers.
      if (bram_enb) begin
        v1_q <= issue;
        l1_q <= issue & last_issue;
        v2_q <= v1_q;
        l2_q <= l1_q;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_doutb;
      fifo_last[wr_ptr] <= l2_q;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: an enable-gated 2-stage BRAM model with mem[i]=i, a queue of
// expected {last, data} words built from base/length, and directed plus random transfers.
module tb_bram_stream_reader;

  localparam int RW    = 32;
  localparam int AW    = 10;
  localparam int FD    = 4;
  localparam int DEPTH = 1024;

  logic          clka  = 1'b0;
  logic          rstb  = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length    = '0;
  logic          busy, done, bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [RW-1:0] bram_doutb;
  logic [RW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;
  int max_occ  = 0;
  int ready_mode = 0;
  int low_left   = 0;
  bit expect_done = 1'b0;
  logic [RW:0] exp_q[$];

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] bram_r1;

  bram_stream_reader #(.RAM_WIDTH(RW), .L2_RAM_DEPTH(AW), .FIFO_DEPTH(FD)) dut (
    .clka(clka), .rstb(rstb), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
    .bram_doutb(bram_doutb), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clka = ~clka;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // BRAM model: both registers load only when enb is high
  initial for (int i = 0; i < DEPTH; i++) mem[i] = RW'(i);

  always @(posedge clka) begin
    if (rstb) begin
      bram_r1    <= '0;
      bram_doutb <= '0;
    end else if (bram_enb) begin
      bram_r1    <= mem[bram_addrb];
      bram_doutb <= bram_r1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // m_ready driver: always high, or random with long low stretches
  initial begin
    forever begin
      @(posedge clka);
      #2;
      if (ready_mode == 0) m_ready = 1'b1;
      else if (low_left > 0) begin
        m_ready = 1'b0;
        low_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        low_left = $urandom_range(4, 24);
        m_ready  = 1'b0;
      end else m_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard
  always @(negedge clka) begin
    logic [RW:0] e;
    int occ;
    if (!rstb) begin
      if (done) done_cnt++;
      if (expect_done) begin
        check("done_after_last", done, 1);
        check("busy_fall", busy, 0);
        expect_done = 1'b0;
      end
      if (m_valid && m_ready) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[RW-1:0]);
          check("m_last", m_last, e[RW]);
          if (e[RW]) expect_done = 1'b1;
        end
      end
      occ = int'(dut.count_q) + int'(dut.v1_q) + int'(dut.v2_q);
      if (occ > max_occ) max_occ = occ;
    end
  end

  // driver tasks
  task automatic start_xfer(input logic [AW-1:0] b, input int len);
    @(posedge clka);
    #2;
    start     = 1'b1;
    base_addr = b;
    length    = (AW+1)'(len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), mem[(int'(b) + i) % DEPTH]});
    exp_done_cnt++;
    @(posedge clka);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy || expect_done) && k < budget) begin
      @(negedge clka);
      k++;
    end
    check("completed_in_budget", k < budget, 1);
    @(negedge clka);
  endtask

  initial begin
    logic [AW-1:0] wrap_a [4];
    wrap_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    repeat (3) @(posedge clka);
    @(negedge clka);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_enb", bram_enb, 0);
    check("rst_addrb", bram_addrb, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clka);
    #2;
    rstb = 1'b0;

    // basic transfer: latency and back-to-back stream
    start_xfer(10'h010, 8);
    @(negedge clka);
    check("t1_busy", busy, 1);
    check("t1_enb", bram_enb, 1);
    check("t1_addrb", bram_addrb, 10'h010);
    @(negedge clka);
    check("t2_m_valid", m_valid, 0);
    @(negedge clka);
    check("t3_m_valid", m_valid, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clka);
      check("stream_valid", m_valid, 1);
    end
    wait_idle(100);
    check("enb_idle", bram_enb, 0);

    // wrap past the top of memory
    start_xfer(10'h3FE, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clka);
      check("wrap_enb", bram_enb, 1);
      check("wrap_addrb", bram_addrb, wrap_a[k]);
    end
    wait_idle(100);

    // zero length
    start_xfer(10'h055, 0);
    @(negedge clka);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_enb", bram_enb, 0);
    check("len0_m_valid", m_valid, 0);
    @(negedge clka);
    check("len0_done_pulse", done, 0);
    check("len0_enb_after", bram_enb, 0);

    // start during an active transfer is ignored
    start_xfer(10'h040, 12);
    repeat (3) @(posedge clka);
    #2;
    start     = 1'b1;
    base_addr = 10'h300;
    length    = 11'd5;
    @(posedge clka);
    #2;
    start = 1'b0;
    wait_idle(200);

    // backpressure
    ready_mode = 1;
    max_occ    = 0;
    start_xfer(10'h080, 16);
    wait_idle(3000);
    check("bp_occupancy_le_depth", max_occ <= FD, 1);

    // random transfers
    for (int r = 0; r < 8; r++) begin
      ready_mode = $urandom_range(0, 1);
      start_xfer(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 40));
      wait_idle(3000);
    end
    check("rand_occupancy_le_depth", max_occ <= FD, 1);

    // reset in the middle of a transfer
    ready_mode = 0;
    start_xfer(10'h020, 8);
    repeat (5) begin
      @(posedge clka);
      #2;
    end
    rstb = 1'b1;
    exp_q.delete();
    expect_done = 1'b0;
    exp_done_cnt--;
    @(posedge clka);
    #2;
    rstb = 1'b0;
    @(negedge clka);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_enb", bram_enb, 0);
    check("mid_rst_addrb", bram_addrb, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_state", dbg_state, 0);
    start_xfer(10'h100, 2);
    wait_idle(100);

    // full memory depth
    max_occ = 0;
    start_xfer(10'h200, 1024);
    wait_idle(1500);
    check("full_occupancy_le_depth", max_occ <= FD, 1);

    repeat (3) @(negedge clka);
    check("done_count", done_cnt, exp_done_cnt);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
